key_event: RTL and testbench
============================

Name: key_event

Overview:
- Consumer-side partner of the key debouncer: takes one debounced key level and decodes it into registered one-cycle event pulses: press, release, click, double-click, long-press and auto-repeat.
- Sits between the debouncer output and application logic (menus, mode select, counters).
- All timing is counted in ticks from an internal prescaler, so thresholds are expressed in human time units.

Parameters:
- TICK_DIV, 16'd50000, clock cycles per tick (1 ms at 50 MHz); must be >= 2.
- LONG_T, 16'd800, ticks a key must be held before long_o fires; must be >= 1.
- REPEAT_T, 16'd150, ticks between repeat_o pulses while long-held; must be >= 1.
- DCLICK_T, 16'd250, ticks allowed between the first release and the second press; 0 disables double-click detection.

Ports:
- clk  input  1  single system clock; everything is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_i  input  1  debounced key level, 1 = pressed; synchronous to clk.
- press_o  output  1  one-cycle pulse on each accepted press.
- release_o  output  1  one-cycle pulse on each release.
- click_o  output  1  one-cycle pulse when a short press completes as a single click.
- dclick_o  output  1  one-cycle pulse when a double-click completes.
- long_o  output  1  one-cycle pulse when the hold reaches LONG_T.
- repeat_o  output  1  periodic one-cycle pulse while long-held.
- held_o  output  1  level, high while the key is considered pressed.

Behaviour:
- Reset: all outputs 0; state IDLE; key_d = 0; armed = 0; prescaler = 0; tick count = 0.
- Reset asserted mid-operation aborts all activity immediately. No event is emitted on reset entry or reset exit.
- armed sets on the first cycle key_i is sampled 0. No press is recognised until armed = 1, so a key held through reset produces no events until it is released and pressed again.
- Edges: key_d <= key_i each cycle. rise = key_i & ~key_d & armed. fall = ~key_i & key_d.
- Outputs are registered. A pulse is high in the cycle after the cycle in which its condition was sampled.
- Timer:
  - Prescaler counts 0..TICK_DIV-1; wrap produces a tick.
  - Tick count increments on each tick, saturating at 16'hFFFF.
  - Prescaler and tick count both clear on every state transition, so thresholds are exact: N ticks = N*TICK_DIV cycles after state entry.
- States, one-hot:
  - IDLE:
    - rise -> press_o, go to PRESSED.
  - PRESSED (held_o = 1):
    - fall -> release_o. If DCLICK_T = 0: click_o, go to IDLE. Otherwise go to WAIT2.
    - tick count reaches LONG_T -> long_o, go to LHELD.
  - LHELD (held_o = 1):
    - repeat_o fires every REPEAT_T ticks; the first one is REPEAT_T*TICK_DIV cycles after long_o.
    - fall -> release_o, go to IDLE. No click.
  - WAIT2:
    - rise -> press_o, go to PRESSED2.
    - tick count reaches DCLICK_T -> click_o, go to IDLE.
  - PRESSED2 (held_o = 1):
    - fall -> release_o and dclick_o in the same cycle, go to IDLE.
    - tick count reaches LONG_T -> click_o and long_o in the same cycle (the first click is not lost), go to LHELD.
- Simultaneous events:
  - An edge on key_i beats timer expiry in the same cycle.
  - In WAIT2, a rise coincident with DCLICK_T expiry counts as a double-click attempt.
- No two of press_o, release_o and repeat_o are ever high in the same cycle.
- held_o rises with press_o and falls with release_o.

Decomposition:
- Shared package holds:
  - state encodings: IDLE=5'b00001, PRESSED=5'b00010, LHELD=5'b00100, WAIT2=5'b01000, PRESSED2=5'b10000;
  - tick count width constant TW=16.
- One sub-module, tick_gen:
  - inputs clk, rst, clr; output tick;
  - parameter TICK_DIV;
  - holds the prescaler.
- The tick counter and the FSM stay in key_event.

Test Plan (TICK_DIV=4, LONG_T=5, REPEAT_T=2, DCLICK_T=3):
- Short click: key_i high 8 cycles, then low -> press_o one cycle after the rise, release_o one cycle after the fall, click_o 12 cycles after release_o, held_o high exactly between press_o and release_o.
- Double-click: high 8, low 6, high 8, low -> press_o twice, one release_o plus dclick_o in the same cycle at the end, click_o never asserted.
- Long hold with repeat: high 40 cycles -> long_o 20 cycles after press_o, repeat_o at +8 and +16 after long_o, release_o on the fall, no click_o.
- Second press held long: click, then second press held 25 cycles -> click_o and long_o together 20 cycles after the second press_o.
- Held through reset: key_i = 1 while rst pulses, held 30 more cycles -> no outputs. Then low, then high -> normal press_o.
- Reset mid-hold and edge/expiry race:
  - assert rst in LHELD -> all outputs 0 at once, state IDLE;
  - a fall sampled on the exact expiry cycle of LONG_T -> release_o (plus click_o or WAIT2 entry), no long_o.

Source files
------------

// File: rtl/key_event_pkg.sv
// key_event_pkg: shared definitions for the key event decoder.
//   state_t : one-hot FSM encoding (also exported on the debug state field)
//   TW      : width of the tick counter and of the timing parameters
//   sat_inc : saturating increment used by the tick counter
package key_event_pkg;

  localparam int TW = 16;

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    PRESSED  = 5'b00010,
    LHELD    = 5'b00100,
    WAIT2    = 5'b01000,
    PRESSED2 = 5'b10000
  } state_t;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v, input logic en);
    return (en && (v != '1)) ? v + TW'(1) : v;
  endfunction

endpackage

// File: rtl/key_event_if.sv
// key_event_if: bundle between the debounced key source and the event decoder.
//   key_i      : debounced key level (1 = pressed), sampled every clock
//   press_o .. repeat_o : registered one-cycle event pulses
//   held_o     : level, high while the key is considered pressed
//   dbg_state  : current FSM state, for checkers and debug
// Handshake: none. key_i is a plain level sampled on every rising clk edge; each
// event output is a single-cycle pulse that the consumer must sample that cycle
// (there is no ready/backpressure, an unsampled pulse is lost).
// Modports: master = key source / event consumer, slave = the decoder.
interface key_event_if;
  import key_event_pkg::*;

  logic   key_i;
  logic   press_o;
  logic   release_o;
  logic   click_o;
  logic   dclick_o;
  logic   long_o;
  logic   repeat_o;
  logic   held_o;
  state_t dbg_state;

  modport master (
    output key_i,
    input  press_o, release_o, click_o, dclick_o, long_o, repeat_o, held_o, dbg_state
  );

  modport slave (
    input  key_i,
    output press_o, release_o, click_o, dclick_o, long_o, repeat_o, held_o, dbg_state
  );

endinterface

// File: rtl/key_event_tick_gen.sv
// tick_gen: prescaler producing one tick every TICK_DIV clock cycles.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   clr  : restart the prescaler from 0 (used on every FSM state change)
//   tick : high during the last cycle of each TICK_DIV-cycle period
module tick_gen
  import key_event_pkg::*;
#(
  parameter logic [TW-1:0] TICK_DIV = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [TW-1:0] presc;

  // tick does not depend on clr: the FSM uses tick to decide whether to change
  // state, and that decision is what drives clr.
  assign tick = (presc == TICK_DIV - TW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (clr || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + TW'(1);
    end
  end

endmodule

// File: rtl/key_event.sv
// key_event: decodes a debounced key level into registered one-cycle events:
// press, release, click, double-click, long-press and auto-repeat.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : key_event_if.slave (key_i in; event pulses, held_o, dbg_state out)
// Timing parameters are in ticks of TICK_DIV clock cycles. The prescaler and
// tick counter restart on every state change, so a threshold of N ticks fires
// exactly N*TICK_DIV cycles after the state was entered.
module key_event
  import key_event_pkg::*;
#(
  parameter logic [TW-1:0] TICK_DIV = 16'd50000,
  parameter logic [TW-1:0] LONG_T   = 16'd800,
  parameter logic [TW-1:0] REPEAT_T = 16'd150,
  parameter logic [TW-1:0] DCLICK_T = 16'd250
) (
  input  logic        clk,
  input  logic        rst,
  key_event_if.slave  bus
);

  state_t        state_q, state_d;
  logic          key_d, armed;
  logic          rise, fall;
  logic          tick, clr, rep_fire;
  logic [TW-1:0] tcnt, tnext;
  logic          long_hit, dclick_hit, rep_hit;
  logic          press_d, release_d, click_d, dclick_d, long_d, repeat_d, held_d;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // A press only counts once the key has been seen released after reset, so a
  // key held through reset stays silent until it is let go.
  assign rise = bus.key_i & ~key_d & armed;
  assign fall = ~bus.key_i & key_d;

  // Thresholds are compared against the value the counter is about to take, so
  // the event pulse (one cycle later) lands exactly on the N-tick boundary.
  assign tnext      = sat_inc(tcnt, tick);
  assign long_hit   = tick && (tnext == LONG_T);
  assign dclick_hit = tick && (tnext == DCLICK_T);
  assign rep_hit    = tick && (tnext == REPEAT_T);

  assign clr = (state_d != state_q);

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    dclick_d  = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    rep_fire  = 1'b0;
    // Key edges are tested before timer expiry in every state: an edge wins.
    case (state_q)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (fall) begin
          release_d = 1'b1;
          if (DCLICK_T == '0) begin
            click_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT2;
          end
        end else if (long_hit) begin
          long_d  = 1'b1;
          state_d = LHELD;
        end
      end
      LHELD: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end else if (rep_hit) begin
          // Restart the tick count for the next repeat interval; the
          // prescaler has just wrapped, so the period stays exact.
          repeat_d = 1'b1;
          rep_fire = 1'b1;
        end
      end
      WAIT2: begin
        if (rise) begin
          press_d = 1'b1;
          state_d = PRESSED2;
        end else if (dclick_hit) begin
          click_d = 1'b1;
          state_d = IDLE;
        end
      end
      PRESSED2: begin
        if (fall) begin
          release_d = 1'b1;
          dclick_d  = 1'b1;
          state_d   = IDLE;
        end else if (long_hit) begin
          // The first press was a complete click; report it with the long press.
          click_d = 1'b1;
          long_d  = 1'b1;
          state_d = LHELD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign held_d = (state_d == PRESSED) || (state_d == LHELD) || (state_d == PRESSED2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      key_d         <= 1'b0;
      armed         <= 1'b0;
      tcnt          <= '0;
      bus.press_o   <= 1'b0;
      bus.release_o <= 1'b0;
      bus.click_o   <= 1'b0;
      bus.dclick_o  <= 1'b0;
      bus.long_o    <= 1'b0;
      bus.repeat_o  <= 1'b0;
      bus.held_o    <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_d         <= bus.key_i;
      armed         <= armed | ~bus.key_i;
      tcnt          <= (clr || rep_fire) ? '0 : tnext;
      bus.press_o   <= press_d;
      bus.release_o <= release_d;
      bus.click_o   <= click_d;
      bus.dclick_o  <= dclick_d;
      bus.long_o    <= long_d;
      bus.repeat_o  <= repeat_d;
      bus.held_o    <= held_d;
    end
  end

  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed bench for key_event with TICK_DIV=4, LONG_T=5,
// REPEAT_T=2, DCLICK_T=3 (dut) and the same with DCLICK_T=0 (dut_z).
// Each driven cycle gets an index t; every pulse seen is appended to a trace
// string as <tag><t> (p=press r=release c=click d=dclick l=long q=repeat), and
// each test compares the trace against a hand-derived expectation.
module tb_key_event;
  import key_event_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_event_if bus();
  key_event_if bus_z();

  key_event #(.TICK_DIV(16'd4), .LONG_T(16'd5), .REPEAT_T(16'd2), .DCLICK_T(16'd3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  key_event #(.TICK_DIV(16'd4), .LONG_T(16'd5), .REPEAT_T(16'd2), .DCLICK_T(16'd0)) dut_z (
    .clk (clk),
    .rst (rst),
    .bus (bus_z.slave)
  );

  // ---------------- bookkeeping ----------------
  int    checks = 0;
  int    errors = 0;
  int    t;
  string tr, tr_z, exp;
  int    held_cnt, held_first;

  function automatic string add_ev(input string s, input logic on, input string tag, input int cyc);
    if (on !== 1'b1) return s;
    if (s.len() == 0) return $sformatf("%s%0d", tag, cyc);
    return $sformatf("%s %s%0d", s, tag, cyc);
  endfunction

  task automatic clear();
    t          = 0;
    tr         = "";
    tr_z       = "";
    held_cnt   = 0;
    held_first = -1;
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; holds key level k for n cycles and
  // records the outputs of each cycle at its falling edge.
  task automatic drive(input logic k, input int n);
    for (int i = 0; i < n; i++) begin
      bus.key_i   = k;
      bus_z.key_i = k;
      @(negedge clk);
      tr = add_ev(tr, bus.press_o,   "p", t);
      tr = add_ev(tr, bus.release_o, "r", t);
      tr = add_ev(tr, bus.click_o,   "c", t);
      tr = add_ev(tr, bus.dclick_o,  "d", t);
      tr = add_ev(tr, bus.long_o,    "l", t);
      tr = add_ev(tr, bus.repeat_o,  "q", t);
      tr_z = add_ev(tr_z, bus_z.press_o,   "p", t);
      tr_z = add_ev(tr_z, bus_z.release_o, "r", t);
      tr_z = add_ev(tr_z, bus_z.click_o,   "c", t);
      tr_z = add_ev(tr_z, bus_z.dclick_o,  "d", t);
      tr_z = add_ev(tr_z, bus_z.long_o,    "l", t);
      tr_z = add_ev(tr_z, bus_z.repeat_o,  "q", t);
      if (bus.held_o === 1'b1) begin
        held_cnt++;
        if (held_first < 0) held_first = t;
      end
      t++;
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [6:0] outs;
    bus.key_i   = 1'b0;
    bus_z.key_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    outs = {bus.press_o, bus.release_o, bus.click_o, bus.dclick_o, bus.long_o, bus.repeat_o, bus.held_o};
    checks++;
    if (outs !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", outs, 7'b0);
    end
    checks++;
    if (bus.dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", bus.dbg_state, IDLE);
    end
    rst = 1'b0;
    clear();
    drive(1'b0, 5);
    checks++;
    if (tr != "" || bus.dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_exit: got trace '%s' state %b want trace '' state %b", tr, bus.dbg_state, IDLE);
    end
  endtask

  task automatic test_short_click();
    clear();
    drive(1'b1, 8);
    drive(1'b0, 20);
    exp = "p1 r9 c21";
    checks++;
    if (tr != exp) begin
      errors++;
      $display("FAIL short_trace: got '%s' want '%s'", tr, exp);
    end
    checks++;
    if (held_first !== 1 || held_cnt !== 8) begin
      errors++;
      $display("FAIL short_held: got first %0d count %0d want first 1 count 8", held_first, held_cnt);
    end
    exp = "p1 r9 c9";
    checks++;
    if (tr_z != exp) begin
      errors++;
      $display("FAIL short_nodclick_trace: got '%s' want '%s'", tr_z, exp);
    end
  endtask

  task automatic test_double_click();
    clear();
    drive(1'b1, 8);
    drive(1'b0, 6);
    drive(1'b1, 8);
    drive(1'b0, 20);
    exp = "p1 r9 p15 r23 d23";
    checks++;
    if (tr != exp) begin
      errors++;
      $display("FAIL dclick_trace: got '%s' want '%s'", tr, exp);
    end
    checks++;
    if (held_cnt !== 16) begin
      errors++;
      $display("FAIL dclick_held: got count %0d want 16", held_cnt);
    end
    exp = "p1 r9 c9 p15 r23 c23";
    checks++;
    if (tr_z != exp) begin
      errors++;
      $display("FAIL dclick_nodclick_trace: got '%s' want '%s'", tr_z, exp);
    end
  endtask

  task automatic test_long_repeat();
    clear();
    drive(1'b1, 40);
    drive(1'b0, 10);
    exp = "p1 l21 q29 q37 r41";
    checks++;
    if (tr != exp) begin
      errors++;
      $display("FAIL long_trace: got '%s' want '%s'", tr, exp);
    end
    checks++;
    if (held_first !== 1 || held_cnt !== 40) begin
      errors++;
      $display("FAIL long_held: got first %0d count %0d want first 1 count 40", held_first, held_cnt);
    end
  endtask

  task automatic test_second_long();
    clear();
    drive(1'b1, 8);
    drive(1'b0, 6);
    drive(1'b1, 25);
    drive(1'b0, 15);
    exp = "p1 r9 p15 c35 l35 r40";
    checks++;
    if (tr != exp) begin
      errors++;
      $display("FAIL second_long_trace: got '%s' want '%s'", tr, exp);
    end
    checks++;
    if (held_cnt !== 33) begin
      errors++;
      $display("FAIL second_long_held: got count %0d want 33", held_cnt);
    end
  endtask

  task automatic test_race();
    // Fall sampled on the LONG_T expiry cycle: release wins, then single click.
    clear();
    drive(1'b1, 20);
    drive(1'b0, 20);
    exp = "p1 r21 c33";
    checks++;
    if (tr != exp) begin
      errors++;
      $display("FAIL race_long_fall: got '%s' want '%s'", tr, exp);
    end
    // One cycle longer: long fires first, release then comes from LHELD.
    clear();
    drive(1'b1, 21);
    drive(1'b0, 10);
    exp = "p1 l21 r22";
    checks++;
    if (tr != exp) begin
      errors++;
      $display("FAIL race_long_hold: got '%s' want '%s'", tr, exp);
    end
    // Second rise sampled on the DCLICK_T expiry cycle: still a double-click.
    clear();
    drive(1'b1, 8);
    drive(1'b0, 12);
    drive(1'b1, 8);
    drive(1'b0, 20);
    exp = "p1 r9 p21 r29 d29";
    checks++;
    if (tr != exp) begin
      errors++;
      $display("FAIL race_dclick_rise: got '%s' want '%s'", tr, exp);
    end
    // Second rise one cycle after expiry: click, then a fresh press.
    clear();
    drive(1'b1, 8);
    drive(1'b0, 13);
    drive(1'b1, 8);
    drive(1'b0, 20);
    exp = "p1 r9 c21 p22 r30 c42";
    checks++;
    if (tr != exp) begin
      errors++;
      $display("FAIL race_dclick_late: got '%s' want '%s'", tr, exp);
    end
  endtask

  task automatic test_held_through_reset();
    bus.key_i   = 1'b1;
    bus_z.key_i = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear();
    drive(1'b1, 30);
    drive(1'b0, 5);
    drive(1'b1, 8);
    drive(1'b0, 20);
    exp = "p36 r44 c56";
    checks++;
    if (tr != exp) begin
      errors++;
      $display("FAIL held_reset_trace: got '%s' want '%s'", tr, exp);
    end
    checks++;
    if (held_first !== 36 || held_cnt !== 8) begin
      errors++;
      $display("FAIL held_reset_held: got first %0d count %0d want first 36 count 8", held_first, held_cnt);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [6:0] outs;
    clear();
    drive(1'b1, 25);
    exp = "p1 l21";
    checks++;
    if (tr != exp || bus.held_o !== 1'b1 || bus.dbg_state !== LHELD) begin
      errors++;
      $display("FAIL midhold_pre: got '%s' held %b state %b want '%s' held 1 state %b",
               tr, bus.held_o, bus.dbg_state, exp, LHELD);
    end
    rst = 1'b1;
    #1;
    outs = {bus.press_o, bus.release_o, bus.click_o, bus.dclick_o, bus.long_o, bus.repeat_o, bus.held_o};
    checks++;
    if (outs !== 7'b0 || bus.dbg_state !== IDLE) begin
      errors++;
      $display("FAIL midhold_reset: got outs %b state %b want outs %b state %b", outs, bus.dbg_state, 7'b0, IDLE);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear();
    drive(1'b1, 10);
    drive(1'b0, 6);
    drive(1'b1, 8);
    drive(1'b0, 20);
    exp = "p17 r25 c37";
    checks++;
    if (tr != exp) begin
      errors++;
      $display("FAIL midhold_after: got '%s' want '%s'", tr, exp);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.key_i   = 1'b0;
    bus_z.key_i = 1'b0;
    test_reset();
    test_short_click();
    test_double_click();
    test_long_repeat();
    test_second_long();
    test_race();
    test_held_through_reset();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
